// File: rtl/result_bcd_pkg.sv
// Shared types and constants for the result-to-BCD conversion path.
package result_bcd_pkg;

  // Conversion sequencer states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ABS   = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Width of one BCD digit.
  localparam int DIGIT_W = 4;

  // Double-dabble adjust: digits at or above the threshold get the add value
  // so the following left shift carries correctly into the next digit.
  localparam logic [DIGIT_W-1:0] BCD_ADJ_THRESH = 4'd5;
  localparam logic [DIGIT_W-1:0] BCD_ADJ_ADD    = 4'd3;

endpackage

// File: rtl/bcd_digit_adj.sv
// Single-digit double-dabble adjust: adds 3 to a BCD digit that is 5 or more.
// No carry leaves the digit; the following shift handles digit-to-digit flow.
module bcd_digit_adj
  import result_bcd_pkg::*;
(
  input  logic [DIGIT_W-1:0] din,
  output logic [DIGIT_W-1:0] dout
);

  // Conditional add-3 on one nibble.
  always_comb begin
    dout = din;
    if (din >= BCD_ADJ_THRESH) begin
      dout = din + BCD_ADJ_ADD;
    end
  end

endmodule

// File: rtl/result_bcd_converter.sv
// Iterative binary-to-BCD converter for the result display.
// A one-cycle start in IDLE captures the result word; the magnitude is
// formed in ABS, then one bit per cycle is shifted through the BCD scratch
// register. bcd/neg/blank update together with the one-cycle done pulse and
// are held until the next conversion or a clear.
// Optional macro RESULT_BCD_BLANK_EN enables the leading-zero blank mask;
// without it, blank is always zero.
//
// Handshake: start is a request that is honoured only while busy is low
// (IDLE); requests at any other time are dropped, never queued. done is a
// single-cycle strobe marking the first cycle the new outputs are valid.
module result_bcd_converter
  import result_bcd_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       clear,
  input  logic                       start,
  input  logic [WIDTH-1:0]           value,
  input  logic                       is_signed,
  output logic [DIGIT_W*DIGITS-1:0]  bcd,
  output logic                       neg,
  output logic                       busy,
  output logic                       done,
  output logic [DIGITS-1:0]          blank,
  output state_t                     state_dbg
);

  localparam int BCD_W = DIGIT_W * DIGITS;
  localparam int CNT_W = $clog2(WIDTH + 1);

  state_t             state_q,     state_d;
  logic [WIDTH-1:0]   mag_q,       mag_d;
  logic               sign_mode_q, sign_mode_d;
  logic               neg_int_q,   neg_int_d;
  logic [BCD_W-1:0]   scratch_q,   scratch_d;
  logic [CNT_W-1:0]   cnt_q,       cnt_d;
  logic [BCD_W-1:0]   bcd_q,       bcd_d;
  logic               neg_q,       neg_d;
  logic               done_q,      done_d;
  logic [DIGITS-1:0]  blank_q,     blank_d;

  logic [BCD_W-1:0]   adj;
  logic [BCD_W-1:0]   scratch_shift;
  logic [WIDTH-1:0]   mag_shift;
  logic [DIGITS-1:0]  blank_calc;
  // The adjusted top bit falls off the shift; it is always zero when
  // 10^DIGITS > 2^WIDTH holds.
  logic               adj_top_unused;

  genvar g;
  generate
    for (g = 0; g < DIGITS; g++) begin : g_adj
      bcd_digit_adj u_adj (
        .din  (scratch_q[g*DIGIT_W +: DIGIT_W]),
        .dout (adj[g*DIGIT_W +: DIGIT_W])
      );
    end
  endgenerate

  assign scratch_shift  = {adj[BCD_W-2:0], mag_q[WIDTH-1]};
  assign mag_shift      = {mag_q[WIDTH-2:0], 1'b0};
  assign adj_top_unused = adj[BCD_W-1];

`ifdef RESULT_BCD_BLANK_EN
  // Blank every digit above the most significant non-zero one; digit 0 stays lit.
  always_comb begin
    logic nz_seen;
    nz_seen    = 1'b0;
    blank_calc = '0;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      if (scratch_shift[k*DIGIT_W +: DIGIT_W] != '0) begin
        nz_seen = 1'b1;
      end
      blank_calc[k] = ~nz_seen;
    end
  end
`else
  // Blanking disabled: mask is constant zero.
  always_comb begin
    blank_calc = '0;
  end
`endif

  // Next-state and datapath for the conversion sequencer.
  always_comb begin
    state_d     = state_q;
    mag_d       = mag_q;
    sign_mode_d = sign_mode_q;
    neg_int_d   = neg_int_q;
    scratch_d   = scratch_q;
    cnt_d       = cnt_q;
    bcd_d       = bcd_q;
    neg_d       = neg_q;
    done_d      = 1'b0;
    blank_d     = blank_q;

    if (clear) begin
      state_d     = IDLE;
      mag_d       = '0;
      sign_mode_d = 1'b0;
      neg_int_d   = 1'b0;
      scratch_d   = '0;
      cnt_d       = '0;
      bcd_d       = '0;
      neg_d       = 1'b0;
      blank_d     = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            mag_d       = value;
            sign_mode_d = is_signed;
            state_d     = ABS;
          end
        end
        ABS: begin
          // Most-negative value negates to 2^(WIDTH-1), still fits unsigned.
          if (sign_mode_q && mag_q[WIDTH-1]) begin
            mag_d     = ~mag_q + WIDTH'(1);
            neg_int_d = 1'b1;
          end else begin
            neg_int_d = 1'b0;
          end
          scratch_d = '0;
          cnt_d     = CNT_W'(WIDTH);
          state_d   = SHIFT;
        end
        SHIFT: begin
          scratch_d = scratch_shift;
          mag_d     = mag_shift;
          cnt_d     = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            // Last shift: publish the result so it is visible with done.
            bcd_d   = scratch_shift;
            neg_d   = neg_int_q;
            blank_d = blank_calc;
            done_d  = 1'b1;
            state_d = DONE;
          end
        end
        DONE: begin
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      mag_q       <= '0;
      sign_mode_q <= 1'b0;
      neg_int_q   <= 1'b0;
      scratch_q   <= '0;
      cnt_q       <= '0;
      bcd_q       <= '0;
      neg_q       <= 1'b0;
      done_q      <= 1'b0;
      blank_q     <= '0;
    end else begin
      state_q     <= state_d;
      mag_q       <= mag_d;
      sign_mode_q <= sign_mode_d;
      neg_int_q   <= neg_int_d;
      scratch_q   <= scratch_d;
      cnt_q       <= cnt_d;
      bcd_q       <= bcd_d;
      neg_q       <= neg_d;
      done_q      <= done_d;
      blank_q     <= blank_d;
    end
  end

  assign bcd       = bcd_q;
  assign neg       = neg_q;
  assign done      = done_q;
  assign blank     = blank_q;
  assign busy      = (state_q != IDLE);
  assign state_dbg = state_q;

endmodule

// File: doc/result_bcd_converter.md
Name: result_bcd_converter

Overview:
- Downstream of the arithmetic control unit and datapath. Converts the finished result word to BCD digits for the seven-segment display driver.
- Conversion is triggered by the control unit's one-cycle ready pulse.
- Iterative double-dabble: one result bit per clock, with optional signed interpretation.
- Holds the converted digits stable until the next conversion or until a clear.

Parameters:
- WIDTH, 16, result word width in bits.
- DIGITS, 5, number of BCD output digits. Must satisfy 10^DIGITS > 2^WIDTH.

Ports:
- clk  input  1  clock.
- reset  input  1  asynchronous, active-low reset.
- clear  input  1  synchronous display clear (driven by control unit sys_reset). Aborts any conversion.
- start  input  1  conversion request (control unit ready pulse). Sampled only in IDLE.
- value  input  WIDTH  result word. Sampled on the cycle start is accepted.
- is_signed  input  1  1 = value is two's complement; 0 = value is unsigned. Sampled with value.
- bcd  output  4*DIGITS  digit 0 in bits [3:0] (least significant), up to digit DIGITS-1 in the top nibble.
- neg  output  1  result was negative. Valid with bcd.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse; bcd and neg are updated from this cycle on.
- blank  output  DIGITS  leading-zero blank mask (see Optional Feature).

Behaviour:
- Reset values (asynchronous reset and synchronous clear alike): bcd=0, neg=0, busy=0, done=0, blank=0, state=IDLE, internal shift and iteration registers = 0.
- clear has priority over start and over all state transitions.
- States:
  - IDLE: if start is high, capture value and is_signed; go to ABS. Otherwise stay.
  - ABS: if is_signed=1 and the value MSB is 1, magnitude = two's-complement negation, taken as a WIDTH-bit unsigned result, and the negative flag is set internally. Otherwise magnitude = value. Clear the BCD scratch register, load the iteration counter with WIDTH, go to SHIFT.
  - SHIFT: each cycle, first add 3 to every scratch digit that is >= 5, then shift {scratch, magnitude} left by 1 and decrement the counter. When the counter reaches 1 at the start of a cycle, that cycle performs the final shift and the next state is DONE.
  - DONE: on entry, bcd <= scratch and neg <= the internal negative flag. done=1 for exactly this one cycle. Go to IDLE.
- Latency: start accepted at cycle 0 → ABS at cycle 1 → SHIFT for cycles 2..WIDTH+1 → DONE (done=1, new bcd visible) at cycle WIDTH+2. With WIDTH=16 that is cycle 18.
- Boundary conditions:
  - start while busy: ignored, no queueing. A start pulse that coincides with DONE is also ignored.
  - value = most-negative signed: magnitude 2^(WIDTH-1), which fits in WIDTH unsigned bits; neg=1.
  - Signed zero: neg=0.
  - Reset or clear mid-conversion: abort immediately, apply reset values, done is not pulsed.
  - Outputs are held unchanged between done pulses.
- Width rules: the scratch register is 4*DIGITS bits. Digit adjust is 4-bit add-3, with no carry between digits before the shift.

Optional Feature:
- Macro: RESULT_BCD_BLANK_EN.
- With the macro defined: on DONE, blank[k]=1 for every digit k above the most significant non-zero digit. Digit 0 is never blanked. blank is registered together with bcd.
  - Example: result 7 → blank=5'b11110.
  - Example: result 0 → blank=5'b11110.
- Without the macro: blank is tied to all zeros.

Decomposition:
- Shared package result_bcd_pkg contains:
  - state enum {IDLE, ABS, SHIFT, DONE};
  - constants BCD_ADJ_THRESH=4'd5 and BCD_ADJ_ADD=4'd3;
  - a digit-width constant of 4.
- One sub-module: bcd_digit_adj, combinational 4-bit in/out, output = in>=5 ? in+3 : in. Instantiated DIGITS times via a generate loop.

Test Plan:
- Unsigned conversion: value=16'h1234, is_signed=0, one start pulse → done at cycle 18, bcd=20'h04660, neg=0, busy high during cycles 1–18.
- Signed negative one: value=16'hFFFF, is_signed=1 → bcd=20'h00001, neg=1. Then the same value with is_signed=0 → bcd=20'h65535, neg=0.
- Most-negative signed: value=16'h8000, is_signed=1 → bcd=20'h32768, neg=1. Then value=0 signed → bcd=0, neg=0.
- Start while busy ignored: second start pulse with value=16'd99 at cycle 5 of a conversion of 16'd1234 → single done pulse, bcd=20'h01234; no second done pulse follows.
- Abort: clear at cycle 8 of a conversion of 16'd500, and separately reset low at cycle 10 → bcd=0, busy=0 the next cycle, no done pulse. A new start afterwards converts correctly (500 → 20'h00500).
- RESULT_BCD_BLANK_EN defined: 7 → blank=5'b11110; 40000 unsigned → blank=5'b00000; 0 → blank=5'b11110. Macro undefined → blank=0 in all cases.
